// File: rtl/sc_micro_sequencer.sv
// Next-microaddress generator: control-store address incrementer, branch/decode logic,
// PSR flag register and memory-wait stall with a timeout trap.
module sc_micro_sequencer #(
    parameter int unsigned UADDR_WIDTH = 11,
    parameter logic [UADDR_WIDTH-1:0] RESET_UADDR = 11'd0,
    parameter logic [UADDR_WIDTH-1:0] TRAP_UADDR = 11'd2047,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                   SC_uSeq_CLOCK_50,
    input  logic                   SC_uSeq_RESET_InLow,
    input  logic [2:0]             SC_uSeq_COND_In,
    input  logic [UADDR_WIDTH-1:0] SC_uSeq_JMPADDR_In,
    input  logic [3:0]             SC_uSeq_ALU_In,
    input  logic                   SC_uSeq_RD_In,
    input  logic                   SC_uSeq_WR_In,
    input  logic [3:0]             SC_uSeq_Flags_In,
    input  logic [31:0]            SC_uSeq_IR_In,
    input  logic                   SC_uSeq_MemReady_InHigh,
    output logic [UADDR_WIDTH-1:0] SC_uSeq_uAddr_Out,
    output logic [3:0]             SC_uSeq_PSR_Out,
    output logic                   SC_uSeq_Stall_OutHigh,
    output logic                   SC_uSeq_Error_OutHigh
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [1:0]             state_q, state_d;
    logic [UADDR_WIDTH-1:0] uaddr_q, uaddr_d;
    logic [3:0]             psr_q, psr_d;
    logic                   error_q, error_d;
    logic [7:0]             count_q, count_d;

    logic                   mem_access;
    logic                   mem_pending;
    logic                   timeout;
    logic                   advance;
    logic                   cc_op;
    logic [UADDR_WIDTH-1:0] uaddr_inc;
    logic [UADDR_WIDTH-1:0] uaddr_next;
    logic                   unused;

    assign mem_access  = SC_uSeq_RD_In | SC_uSeq_WR_In;
    assign mem_pending = mem_access & ~SC_uSeq_MemReady_InHigh;
    assign timeout     = (state_q == S_WAIT) && !SC_uSeq_MemReady_InHigh &&
                         (count_q == WAIT_LAST);
    assign cc_op       = (SC_uSeq_ALU_In[3:2] == 2'b00);
    assign uaddr_inc   = uaddr_q + UADDR_WIDTH'(1);
    assign unused      = ^{SC_uSeq_ALU_In[1:0], SC_uSeq_IR_In[29:25], SC_uSeq_IR_In[18:14],
                           SC_uSeq_IR_In[12:0]};

    // Branch conditions use the registered PSR, so a cc-setting op sees the old flags.
    always_comb begin
        uaddr_next = uaddr_inc;
        unique case (SC_uSeq_COND_In)
            3'b000: uaddr_next = uaddr_inc;
            3'b001: uaddr_next = psr_q[3] ? SC_uSeq_JMPADDR_In : uaddr_inc;
            3'b010: uaddr_next = psr_q[2] ? SC_uSeq_JMPADDR_In : uaddr_inc;
            3'b011: uaddr_next = psr_q[1] ? SC_uSeq_JMPADDR_In : uaddr_inc;
            3'b100: uaddr_next = psr_q[0] ? SC_uSeq_JMPADDR_In : uaddr_inc;
            3'b101: uaddr_next = SC_uSeq_IR_In[13] ? SC_uSeq_JMPADDR_In : uaddr_inc;
            3'b110: uaddr_next = SC_uSeq_JMPADDR_In;
            3'b111: uaddr_next = UADDR_WIDTH'({1'b1, SC_uSeq_IR_In[31:30],
                                                SC_uSeq_IR_In[24:19], 2'b00});
            default: uaddr_next = uaddr_inc;
        endcase
    end

    always_comb begin
        state_d = state_q;
        uaddr_d = uaddr_q;
        error_d = error_q;
        count_d = count_q;
        advance = 1'b0;
        unique case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                if (mem_pending) begin
                    count_d = 8'd0;
                    state_d = S_WAIT;
                end else begin
                    uaddr_d = uaddr_next;
                    advance = 1'b1;
                end
            end
            S_WAIT: begin
                count_d = count_q + 8'd1;
                if (SC_uSeq_MemReady_InHigh) begin
                    uaddr_d = uaddr_next;
                    advance = 1'b1;
                    state_d = S_RUN;
                end else if (timeout) begin
                    uaddr_d = TRAP_UADDR;
                    error_d = 1'b1;
                    advance = 1'b1;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_BOOT;
        endcase
        psr_d = (advance && cc_op) ? SC_uSeq_Flags_In : psr_q;
    end

    always_ff @(posedge SC_uSeq_CLOCK_50 or negedge SC_uSeq_RESET_InLow) begin
        if (!SC_uSeq_RESET_InLow) begin
            state_q <= S_BOOT;
            uaddr_q <= RESET_UADDR;
            psr_q   <= 4'b0000;
            error_q <= 1'b0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            uaddr_q <= uaddr_d;
            psr_q   <= psr_d;
            error_q <= error_d;
            count_q <= count_d;
        end
    end

    assign SC_uSeq_uAddr_Out     = uaddr_q;
    assign SC_uSeq_PSR_Out       = psr_q;
    assign SC_uSeq_Error_OutHigh = error_q;
    assign SC_uSeq_Stall_OutHigh = (state_q == S_RUN || state_q == S_WAIT) && mem_pending;

endmodule

// File: doc/sc_micro_sequencer.md
Name: sc_micro_sequencer

Overview:
- Next-microaddress generator (control-store address incrementer plus branch logic) for the microprogrammed datapath.
- Consumes the COND, JMP_ADDR, ALU, RD and WR fields of the current microinstruction held in the MIR, plus the ALU flags and the IR.
- Produces the 11-bit control-store address. The ROM behind that address feeds the MIR.
- Keeps the PSR condition flags and stalls the microprogram on slow memory accesses, with a timeout trap.

Parameters:
- UADDR_WIDTH, 11, control-store address width.
- RESET_UADDR, 11'd0, microaddress presented after reset.
- TRAP_UADDR, 11'd2047, microaddress forced on memory timeout.
- MEM_TIMEOUT, 16, maximum wait cycles for memory ready (range 1..255).

Ports:
- SC_uSeq_CLOCK_50  in  1  system clock; all state updates on posedge. The MIR loads on the following negedge.
- SC_uSeq_RESET_InLow  in  1  asynchronous, active-low reset.
- SC_uSeq_COND_In  in  3  MIR COND field.
- SC_uSeq_JMPADDR_In  in  11  MIR JMP_ADDR field.
- SC_uSeq_ALU_In  in  4  MIR ALU field.
- SC_uSeq_RD_In  in  1  MIR RD bit.
- SC_uSeq_WR_In  in  1  MIR WR bit.
- SC_uSeq_Flags_In  in  4  live ALU flags {n,z,v,c}.
- SC_uSeq_IR_In  in  32  instruction register.
- SC_uSeq_MemReady_InHigh  in  1  memory access complete.
- SC_uSeq_uAddr_Out  out  11  registered control-store address.
- SC_uSeq_PSR_Out  out  4  registered flags {n,z,v,c}.
- SC_uSeq_Stall_OutHigh  out  1  combinational; gates register-file and IR writes.
- SC_uSeq_Error_OutHigh  out  1  sticky memory-timeout flag.

Behaviour:
- Reset (async, RESET_InLow=0):
  - uAddr=RESET_UADDR, PSR=4'b0000, Error=0, wait counter=0, state=S_BOOT.
  - Applies immediately, including mid-wait; any pending memory wait is abandoned.
- States:
  - S_BOOT: one cycle; uAddr held at RESET_UADDR so the MIR loads ROM[RESET_UADDR] on the next negedge. Next state S_RUN.
  - S_RUN: at each posedge compute next address (see below).
    - If (RD|WR) and MemReady=0: hold uAddr, clear counter, go to S_WAIT.
    - Otherwise load next address and stay in S_RUN.
  - S_WAIT: counter increments each cycle.
    - If MemReady=1: load next address, go to S_RUN.
    - Else if counter==MEM_TIMEOUT-1: uAddr=TRAP_UADDR, Error=1, go to S_RUN.
    - Else hold.
- Stall_OutHigh = (state==S_RUN or S_WAIT) & (RD|WR) & ~MemReady. It is 0 in S_BOOT.
- Next-address selection by COND, using the PSR value before this edge's update:
  - 000: uAddr+1, mod 2^11 (2047 wraps to 0).
  - 001: JMP_ADDR if n else uAddr+1.
  - 010: JMP_ADDR if z else uAddr+1.
  - 011: JMP_ADDR if v else uAddr+1.
  - 100: JMP_ADDR if c else uAddr+1.
  - 101: JMP_ADDR if IR[13] else uAddr+1.
  - 110: JMP_ADDR unconditionally.
  - 111 (decode): {1'b1, IR[31:30], IR[24:19], 2'b00}.
- PSR update:
  - PSR <= Flags_In on a posedge where ALU_In[3:2]==2'b00 (ANDCC/ORCC/NORCC/ADDCC) and uAddr advances (not held). A timeout-trap edge counts as advancing.
  - No update in S_BOOT or while held.
  - A branch in the same microinstruction as a cc-setting ALU op sees the old flags.
- Error stays set until reset.
- Latency: the address decision is visible on uAddr one posedge after the MIR fields settle.

Test Plan:
- Reset then release; COND=000 throughout.
  - uAddr=0 after reset, stays 0 for the S_BOOT cycle, then 1,2,3 on successive posedges.
  - Preload uAddr=2047 with COND=000: next value 0.
- Branch on z:
  - ALU=0011 (ADDCC) with Flags_In=0100 gives PSR=0100.
  - Next cycle COND=010, JMP_ADDR=0x123: uAddr=0x123.
  - Same sequence with Flags_In=0000: uAddr=previous+1.
- Same-cycle flag hazard:
  - PSR=0000, ALU=0011, Flags_In=0100, COND=010: branch not taken; PSR becomes 0100 on that edge.
- Decode:
  - IR op=11, op3=000000 (ld), COND=111: uAddr=0x700.
  - IR op=10, op3=010000 (addcc): uAddr=0x640.
- Memory wait:
  - RD=1, MemReady low 3 cycles then high: uAddr held 3 cycles, Stall=1 for those cycles, then uAddr advances; Error=0.
- Timeout and reset mid-wait:
  - MEM_TIMEOUT=16, WR=1, MemReady held 0: uAddr=2047 after 16 wait cycles, Error=1.
  - Reset asserted during a wait: uAddr=0, Error=0, Stall=0 immediately.
